fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 14 +
 rtl/fetch_unit_if.sv | 32 +++
 rtl/fetch_fifo.sv | 54 +++++
 rtl/fetch_unit.sv | 84 ++++++++
 tb/tb_fetch_unit.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch slice: default bus widths and
// helpers used by the fetch unit, its queue and its interface.
package fetch_unit_pkg;

    localparam int unsigned ADDR_WIDTH_DFLT = 32;
    localparam int unsigned INST_WIDTH_DFLT = 32;
    localparam int unsigned PC_STEP         = 4;

    // Width needed to hold a count in 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction memory request/response, decode-side
// instruction stream and the redirect input.
interface fetch_unit_if #(
    parameter int unsigned ADDR_WIDTH = fetch_unit_pkg::ADDR_WIDTH_DFLT,
    parameter int unsigned INST_WIDTH = fetch_unit_pkg::INST_WIDTH_DFLT
);

    logic                  imem_req;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic                  imem_gnt;
    logic                  imem_rvalid;
    logic [INST_WIDTH-1:0] imem_rdata;

    logic                  inst_valid;
    logic                  inst_ready;
    logic [INST_WIDTH-1:0] inst;
    logic [ADDR_WIDTH-1:0] inst_pc;

    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_pc;

    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, inst_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc,
        output imem_gnt, imem_rvalid, imem_rdata, inst_ready, redirect_valid, redirect_pc
    );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch queue: DEPTH entries of {pc, instruction}, head visible
// combinationally, flush empties it in one cycle.
module fetch_fifo import fetch_unit_pkg::*; #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && (count_q != CNT_W'(DEPTH));

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: credit-limited sequential prefetch into a small
// queue, with redirect flush and discard of responses already in flight.
module fetch_unit import fetch_unit_pkg::*; #(
    parameter int unsigned           ADDR_WIDTH = ADDR_WIDTH_DFLT,
    parameter int unsigned           INST_WIDTH = INST_WIDTH_DFLT,
    parameter int unsigned           DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input logic         clk,
    input logic         rst,
    fetch_unit_if.master bus
);

    localparam int unsigned       CNT_W     = cnt_width(DEPTH);
    localparam int unsigned       ENTRY_W   = ADDR_WIDTH + INST_WIDTH;
    localparam logic [CNT_W:0]    DEPTH_CNT = (CNT_W + 1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] fetch_pc_q;
    logic [ADDR_WIDTH-1:0] resp_pc_q;
    logic [CNT_W-1:0]      outstanding_q;
    logic [CNT_W-1:0]      drop_q;
    logic [CNT_W-1:0]      occupancy;
    logic [CNT_W:0]        inflight;
    logic [ADDR_WIDTH-1:0] redirect_target;
    logic [ENTRY_W-1:0]    head;
    logic                  fire;
    logic                  push;
    logic                  pop;

    // Credit uses registered counts only, so imem_rvalid never reaches imem_req.
    assign inflight        = {1'b0, occupancy} + {1'b0, outstanding_q};
    assign bus.imem_req    = (inflight < DEPTH_CNT) && !bus.redirect_valid && !rst;
    assign bus.imem_addr   = fetch_pc_q;
    assign fire            = bus.imem_req && bus.imem_gnt;

    assign push            = bus.imem_rvalid && (drop_q == '0) && !bus.redirect_valid;
    assign bus.inst_valid  = (occupancy != '0) && !bus.redirect_valid && !rst;
    assign pop             = bus.inst_valid && bus.inst_ready;
    assign bus.inst_pc     = head[ENTRY_W-1 -: ADDR_WIDTH];
    assign bus.inst        = head[INST_WIDTH-1:0];
    assign redirect_target = bus.redirect_pc & ~ADDR_WIDTH'(3);

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else if (bus.redirect_valid) begin
            // Everything still in flight after this cycle belongs to the old path.
            fetch_pc_q    <= redirect_target;
            resp_pc_q     <= redirect_target;
            outstanding_q <= outstanding_q - CNT_W'(bus.imem_rvalid);
            drop_q        <= outstanding_q - CNT_W'(bus.imem_rvalid);
        end else begin
            if (fire) begin
                fetch_pc_q <= fetch_pc_q + ADDR_WIDTH'(PC_STEP);
            end
            outstanding_q <= outstanding_q + CNT_W'(fire) - CNT_W'(bus.imem_rvalid);
            if (bus.imem_rvalid) begin
                if (drop_q != '0) begin
                    drop_q <= drop_q - CNT_W'(1);
                end else begin
                    resp_pc_q <= resp_pc_q + ADDR_WIDTH'(PC_STEP);
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({resp_pc_q, bus.imem_rdata}),
        .pop       (pop),
        .flush     (bus.redirect_valid),
        .head_data (head),
        .count     (occupancy)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: latency-configurable memory model, scoreboard of
// expected {pc, inst} pushed at grant time, and directed scenario tasks.
module tb_fetch_unit;

    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    int          checks = 0;
    int          errors = 0;
    int          mem_lat = 1;
    int          cyc = 0;
    mreq_t       mq[$];
    exp_t        exp_q[$];
    exp_t        sb_e;
    logic [31:0] exp_pc = 32'h0;
    logic        s_fire = 1'b0, s_rvalid = 1'b0, s_rst = 1'b0, s2_fire = 1'b0;
    logic [31:0] s_addr = 32'h0, s2_addr = 32'h0;

    fetch_unit_if #(.ADDR_WIDTH(32), .INST_WIDTH(32)) bus ();
    fetch_unit_if #(.ADDR_WIDTH(32), .INST_WIDTH(32)) bus2 ();

    fetch_unit #(.DEPTH(4), .RESET_PC(32'h0)) dut (.clk(clk), .rst(rst), .bus(bus));
    fetch_unit #(.DEPTH(4), .RESET_PC(WRAP_PC)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // In-order memory for the main DUT; response due mem_lat cycles after grant.
    always @(negedge clk) begin
        s_fire   = bus.imem_req && bus.imem_gnt;
        s_addr   = bus.imem_addr;
        s_rvalid = bus.imem_rvalid;
        s_rst    = rst;
        s2_fire  = bus2.imem_req && bus2.imem_gnt;
        s2_addr  = bus2.imem_addr;
    end

    always @(posedge clk) begin
        #1;
        cyc++;
        if (s_rst) begin
            mq.delete();
        end else begin
            if (s_rvalid && mq.size() > 0) void'(mq.pop_front());
            if (s_fire) mq.push_back('{addr: s_addr, due: cyc + mem_lat - 1});
        end
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = mem_word(mq[0].addr);
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = 32'h0;
        end
        bus2.imem_rvalid = s2_fire;
        bus2.imem_rdata  = mem_word(s2_addr);
    end

    // Scoreboard: expected fetch address and {pc, inst} stream of the main DUT.
    always @(negedge clk) begin
        if (bus.inst_valid === 1'b1 && bus.inst_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got pc=%h inst=%h, expected nothing queued",
                         bus.inst_pc, bus.inst);
            end else begin
                sb_e = exp_q.pop_front();
                if (bus.inst_pc !== sb_e.pc || bus.inst !== sb_e.data) begin
                    errors++;
                    $display("FAIL pop_data: got pc=%h inst=%h, expected pc=%h inst=%h",
                             bus.inst_pc, bus.inst, sb_e.pc, sb_e.data);
                end
            end
        end
        if (rst) begin
            exp_q.delete();
            exp_pc = 32'h0;
        end else if (bus.redirect_valid) begin
            exp_q.delete();
            exp_pc = bus.redirect_pc & ~32'h3;
        end else if (bus.imem_req === 1'b1 && bus.imem_gnt === 1'b1) begin
            checks++;
            if (bus.imem_addr !== exp_pc) begin
                errors++;
                $display("FAIL fetch_addr: got %h, expected %h", bus.imem_addr, exp_pc);
            end
            exp_q.push_back('{pc: exp_pc, data: mem_word(exp_pc)});
            exp_pc += 32'd4;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Leaves the bench just after the edge that starts the first rst-low cycle.
    task automatic do_reset();
        step(1);
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        step(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.inst_ready = 1'b1;
        mem_lat = 1;
        step(1);
        rst = 1'b1;
        step(1);
        @(negedge clk);
        checks++;
        if (bus.imem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_req: got %b, expected 0", bus.imem_req);
        end
        checks++;
        if (bus.inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b, expected 0", bus.inst_valid);
        end
        step(1);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0 || bus.inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_req: got req=%b addr=%h valid=%b, expected 1 0 0",
                     bus.imem_req, bus.imem_addr, bus.inst_valid);
        end
    endtask

    task automatic test_stream();
        bus.inst_ready = 1'b1;
        bus.imem_gnt = 1'b1;
        mem_lat = 1;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            logic [31:0] want;
            want = 32'((c - 2) * 4);
            @(negedge clk);
            checks++;
            if (c < 2) begin
                if (bus.inst_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_early c=%0d: got valid=%b, expected 0", c, bus.inst_valid);
                end
            end else if (bus.inst_valid !== 1'b1 || bus.inst_pc !== want) begin
                errors++;
                $display("FAIL stream_pc c=%0d: got valid=%b pc=%h, expected 1 %h",
                         c, bus.inst_valid, bus.inst_pc, want);
            end
        end
    endtask

    task automatic test_backpressure();
        int grants;
        grants = 0;
        bus.inst_ready = 1'b0;
        mem_lat = 1;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.imem_req && bus.imem_gnt) grants++;
        end
        checks++;
        if (grants != 4) begin
            errors++;
            $display("FAIL bp_grants: got %0d, expected 4", grants);
        end
        checks++;
        if (bus.imem_req !== 1'b0) begin
            errors++;
            $display("FAIL bp_req_stall: got %b, expected 0", bus.imem_req);
        end
        step(1);
        bus.inst_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'(k * 4)) begin
                errors++;
                $display("FAIL bp_drain k=%0d: got valid=%b pc=%h, expected 1 %h",
                         k, bus.inst_valid, bus.inst_pc, 32'(k * 4));
            end
            if (k == 0) begin
                checks++;
                if (bus.imem_req !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_credit_delay: got req=%b, expected 0", bus.imem_req);
                end
            end
            if (k == 1) begin
                checks++;
                if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h10) begin
                    errors++;
                    $display("FAIL bp_resume: got req=%b addr=%h, expected 1 00000010",
                             bus.imem_req, bus.imem_addr);
                end
            end
        end
    endtask

    task automatic wait_first(input string name, input logic [31:0] want);
        logic found;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (bus.inst_valid === 1'b1) begin
                found = 1'b1;
                checks++;
                if (bus.inst_pc !== want || bus.inst !== mem_word(want)) begin
                    errors++;
                    $display("FAIL %s_first: got pc=%h inst=%h, expected pc=%h inst=%h",
                             name, bus.inst_pc, bus.inst, want, mem_word(want));
                end
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no inst_valid in 20 cycles, expected pc=%h", name, want);
        end
    endtask

    task automatic test_redirect_inflight();
        bus.inst_ready = 1'b1;
        mem_lat = 3;
        do_reset();
        step(3);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h103;
        @(negedge clk);
        checks++;
        if (bus.imem_req !== 1'b0 || bus.inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_cycle: got req=%b valid=%b, expected 0 0",
                     bus.imem_req, bus.inst_valid);
        end
        step(1);
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin
            errors++;
            $display("FAIL redir_req: got req=%b addr=%h, expected 1 00000100",
                     bus.imem_req, bus.imem_addr);
        end
        wait_first("redir", 32'h100);
    endtask

    task automatic test_redirect_collide();
        bus.inst_ready = 1'b1;
        mem_lat = 1;
        do_reset();
        step(5);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h200;
        @(negedge clk);
        checks++;
        if (bus.inst_valid !== 1'b0 || bus.imem_req !== 1'b0) begin
            errors++;
            $display("FAIL collide_cycle: got valid=%b req=%b, expected 0 0",
                     bus.inst_valid, bus.imem_req);
        end
        step(1);
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.inst_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h200) begin
            errors++;
            $display("FAIL collide_after: got valid=%b req=%b addr=%h, expected 0 1 00000200",
                     bus.inst_valid, bus.imem_req, bus.imem_addr);
        end
        wait_first("collide", 32'h200);
    endtask

    task automatic test_back_to_back();
        bus.inst_ready = 1'b1;
        mem_lat = 2;
        do_reset();
        step(4);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h300;
        step(1);
        bus.redirect_pc = 32'h400;
        @(negedge clk);
        checks++;
        if (bus.imem_req !== 1'b0 || bus.inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_cycle: got req=%b valid=%b, expected 0 0",
                     bus.imem_req, bus.inst_valid);
        end
        step(1);
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h400) begin
            errors++;
            $display("FAIL b2b_req: got req=%b addr=%h, expected 1 00000400",
                     bus.imem_req, bus.imem_addr);
        end
        wait_first("b2b", 32'h400);
    endtask

    task automatic test_wrap();
        mem_lat = 1;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            logic [31:0] want;
            want = WRAP_PC + 32'((c - 2) * 4);
            @(negedge clk);
            if (c == 0) begin
                checks++;
                if (bus2.imem_addr !== WRAP_PC) begin
                    errors++;
                    $display("FAIL wrap_first_addr: got %h, expected %h", bus2.imem_addr, WRAP_PC);
                end
            end else if (c >= 2) begin
                checks++;
                if (bus2.inst_valid !== 1'b1 || bus2.inst_pc !== want
                    || bus2.inst !== mem_word(want)) begin
                    errors++;
                    $display("FAIL wrap_pc c=%0d: got valid=%b pc=%h inst=%h, expected 1 %h %h",
                             c, bus2.inst_valid, bus2.inst_pc, bus2.inst, want, mem_word(want));
                end
            end
        end
    endtask

    task automatic test_reset_midop();
        bus.inst_ready = 1'b0;
        mem_lat = 3;
        do_reset();
        step(4);
        @(negedge clk);
        checks++;
        if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0) begin
            errors++;
            $display("FAIL midrst_pre: got valid=%b pc=%h, expected 1 00000000",
                     bus.inst_valid, bus.inst_pc);
        end
        step(1);
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (bus.inst_valid !== 1'b0 || bus.imem_req !== 1'b0) begin
                errors++;
                $display("FAIL midrst_hold k=%0d: got valid=%b req=%b, expected 0 0",
                         k, bus.inst_valid, bus.imem_req);
            end
            step(1);
        end
        rst = 1'b0;
        mem_lat = 1;
        bus.inst_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0 || bus.inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_restart: got req=%b addr=%h valid=%b, expected 1 0 0",
                     bus.imem_req, bus.imem_addr, bus.inst_valid);
        end
        wait_first("midrst", 32'h0);
    endtask

    task automatic test_random();
        mem_lat = 2;
        do_reset();
        for (int c = 0; c < 300; c++) begin
            bus.imem_gnt = ($urandom_range(0, 3) != 0);
            bus.inst_ready = ($urandom_range(0, 1) != 0);
            if ($urandom_range(0, 15) == 0) begin
                bus.redirect_valid = 1'b1;
                bus.redirect_pc = $urandom & 32'h0000_FFFF;
            end else begin
                bus.redirect_valid = 1'b0;
            end
            step(1);
        end
        bus.redirect_valid = 1'b0;
        bus.inst_ready = 1'b1;
        bus.imem_gnt = 1'b0;
        step(15);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL random_drain: got %0d entries never delivered, expected 0", exp_q.size());
        end
        bus.imem_gnt = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        bus.imem_gnt = 1'b1;
        bus.inst_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 32'h0;
        bus2.imem_gnt = 1'b1;
        bus2.inst_ready = 1'b1;
        bus2.redirect_valid = 1'b0;
        bus2.redirect_pc = 32'h0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_collide();
        test_back_to_back();
        test_wrap();
        test_reset_midop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
